serial_rb_subtractor: RTL and testbench



---
 rtl/arith_pkg.sv | 18 +
 rtl/fs_bit.sv | 13 +
 rtl/serial_rb_subtractor.sv | 106 ++++++++++
 tb/tb_serial_rb_subtractor.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared types and constants for the serial arithmetic blocks.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  // Bit-counter width; never zero so the counter stays a legal vector.
  function automatic int cnt_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/fs_bit.sv
// One-bit combinational full subtractor: d = a - b - bin, with borrow out.
module fs_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_rb_subtractor.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - bin, LSB first, one bit per clock.
module serial_rb_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_next;
  logic [WIDTH-1:0] sa, sb;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             msb_a, msb_b;
  logic             d_i, br_next;
  logic             last_bit;
  logic             accept;

  fs_bit u_fs (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (br),
    .d    (d_i),
    .bout (br_next)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign accept   = in_valid & in_ready;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)               state_next = RUN;
      RUN:     if (last_bit)             state_next = DONE;
      DONE:    if (out_valid && out_ready) state_next = IDLE;
      default:                           state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      msb_a <= 1'b0;
      msb_b <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sa    <= a;
            sb    <= b;
            br    <= bin;
            cnt   <= '0;
            msb_a <= a[WIDTH-1];
            msb_b <= b[WIDTH-1];
          end
        end
        RUN: begin
          sa   <= {1'b0, sa[WIDTH-1:1]};
          sb   <= {1'b0, sb[WIDTH-1:1]};
          br   <= br_next;
          diff <= {d_i, diff[WIDTH-1:1]};
          // The final bit carries the result flags; the counter parks at WIDTH-1.
          if (last_bit) begin
            bout <= br_next;
            ovf  <= (msb_a != msb_b) && (d_i != msb_a);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rb_subtractor.sv
// Self-checking bench: directed and random operations against a scoreboard model.
module tb_serial_rb_subtractor;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready, bin;
  logic [W-1:0] a, b;
  logic         in_ready, out_valid, bout, ovf;
  logic [W-1:0] diff;

  int   checks   = 0;
  int   failures = 0;
  res_t sb_q[$];

  serial_rb_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
    logic [W:0] t;
    res_t r;
    t      = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
    r.diff = t[W-1:0];
    r.bout = t[W];
    r.ovf  = (ma[W-1] != mb[W-1]) && (t[W-1] != ma[W-1]);
    return r;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  in_ready,  1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_diff"},      diff,      0);
    check({tag, "_bout"},      bout,      0);
    check({tag, "_ovf"},       ovf,       0);
  endtask

  // One operation; junk drives in_valid with other operands while busy.
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin,
                        input int gap, input bit junk);
    int   n;
    res_t exp, held;
    @(negedge clk);
    check("accept_ready", in_ready, 1);
    a = oa; b = ob; bin = obin; in_valid = 1'b1; out_ready = 1'b0;
    sb_q.push_back(model(oa, ob, obin));
    @(negedge clk);
    in_valid = junk;
    a = ~oa; b = ~ob; bin = ~obin;
    n = 0;
    while (!out_valid && n < 3 * W) begin
      check("busy_in_ready", in_ready, 0);
      @(negedge clk);
      n++;
    end
    check("latency", n, W);
    held = '{diff: diff, bout: bout, ovf: ovf};
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready",  in_ready,  0);
      check("bp_hold",      {diff, bout, ovf}, held);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    check("sb_nonempty", sb_q.size() > 0, 1);
    if (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      check("diff", diff, exp.diff);
      check("bout", bout, exp.bout);
      check("ovf",  ovf,  exp.ovf);
    end
    @(negedge clk);
    out_ready = 1'b0;
    check("post_in_ready",  in_ready,  1);
    check("post_out_valid", out_valid, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    run_op(4'd5, 4'd3, 1'b0, 0, 1'b0);
    run_op(4'd3, 4'd5, 1'b0, 0, 1'b0);
    run_op(4'd0, 4'd0, 1'b1, 0, 1'b0);
    run_op(4'd8, 4'd1, 1'b0, 0, 1'b0);
    run_op(4'd7, 4'd8, 1'b0, 0, 1'b0);

    // Backpressure with competing operands offered throughout.
    run_op(4'd12, 4'd6, 1'b1, 3, 1'b1);

    // Reset during bit 2 of 9 - 4, then rerun the same operation.
    @(negedge clk);
    a = 4'd9; b = 4'd4; bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("midrun_reset");
    run_op(4'd9, 4'd4, 1'b0, 0, 1'b0);

    for (int k = 0; k < 24; k++) begin
      run_op(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    check("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
